spi_reg_ctrl: RTL
=================

// Module: spi_reg_ctrl
// PURPOSE
//  Single-clock controller that sequences the SPI slave frame by frame. It detects frame end, decodes a 16-bit command
//  and reads or writes an 8-bit register bank (CTRL plus PWM settings). It loads the response word for the next frame.
//  It also drives the slave's CPOL/CPHA configuration. It sits between the SPI slave and the PWM channels.
// PARAMETERS
//  NUM_REGS   8      register count incl. CTRL at addr 0; range 2..128
//  SYNC_STAGES 2     flops in spi_busy synchroniser; minimum 2
// PORTS
//  clk           in   1            system clock
//  reset_n       in   1            synchronous, active-low reset
//  spi_busy      in   1            slave busy (async, SPI domain)
//  spi_rx        in   16           slave rx word; stable while spi_busy low
//  spi_rx_enable out  1            to slave rx_enable
//  spi_tx        out  16           to slave tx; latched by slave while deselected
//  cfg_cpol      out  1            CTRL[0] to slave cpol
//  cfg_cpha      out  1            CTRL[1] to slave cpha
//  regs          out  NUM_REGS*8   flattened bank; reg k at [8k+7:8k]
// BEHAVIOUR
//  Frame format: rx[15]=W(1 write/0 read), rx[14:8]=addr, rx[7:0]=wdata.
//  Reset: state IDLE. All regs 0x00. spi_tx=16'h0000. spi_rx_enable=1. cfg_cpol=cfg_cpha=0. Sticky flags 0. frame_cnt=0.
//  Sync: spi_busy passes through SYNC_STAGES flops, then an edge flop. end_evt = sync falling edge; start_evt = sync rising edge.
//   spi_busy pulses or gaps shorter than SYNC_STAGES+1 clk may be missed; this is a system constraint, not an error.
//  FSM: IDLE -> CAPTURE on end_evt -> EXEC -> RESP -> IDLE. One cycle each in CAPTURE/EXEC/RESP.
//   CAPTURE: cmd <= spi_rx.
//   EXEC:
//    addr>=NUM_REGS: no write; rdata=0x00; set bad_addr.
//    Write: reg[addr] <= wdata; rdata=wdata (echo).
//    Read: rdata=reg[addr].
//   RESP: spi_tx <= {ovr,bad_addr,lock_err,1'b0,frame_cnt[3:0], rdata}.
//    Then frame_cnt+1 (wraps 15->0), and reported sticky flags clear in the same cycle.
//  Latency: spi_tx updates exactly 3 clk after the cycle end_evt is asserted. regs update 2 clk after end_evt.
//  spi_rx_enable=1 only in IDLE. It is 0 in CAPTURE/EXEC/RESP so spi_rx cannot change under decode.
//  start_evt while state!=IDLE: set ovr (sticky). The current transaction completes normally.
//  end_evt while state!=IDLE: ignored; that frame is dropped, and ovr is set if not already set.
//  Simultaneous flag set in RESP: a new set wins over clear-on-report.
//  cfg_cpol/cfg_cpha track CTRL[1:0] combinationally from the register. They change only in EXEC, i.e. between frames.
//  CTRL[6:2] are writable storage with no function. Reads return the written value.
//  Reset asserted mid-transaction: the next edge returns to reset state. The in-flight command is discarded.
//  A spi_busy level present at reset release produces no start_evt or end_evt, because the sync flops load the sampled level.
// CONFIGURATION
//  SPI_REG_WPROT_EN defined: CTRL[7]=lock.
//   lock=1: writes to addr 1..NUM_REGS-1 are rejected (no write), set lock_err, rdata=current reg value.
//   CTRL itself stays writable, so unlock is always possible.
//  Not defined: CTRL[7] is plain storage. lock_err is never set and its tx bit reads 0.
// STRUCTURE
//  Package spi_reg_pkg:
//   state enum {IDLE,CAPTURE,EXEC,RESP}
//   field positions: W_BIT=15, ADDR_MSB/LSB=14/8, DATA_MSB/LSB=7/0
//   CTRL_ADDR=0, CPOL_BIT=0, CPHA_BIT=1, LOCK_BIT=7
//   status bit positions in spi_tx[15:8]
//  Sub-module spi_busy_sync: SYNC_STAGES flop chain plus edge flop; outputs start_evt and end_evt.
//  Top holds FSM, register bank, flags and counter.
// TESTING
//  1 Write 0x8155 frame, then read 0x0100 frame -> regs[15:8]=0x55; second frame's following spi_tx=16'h0155 (frame_cnt=1).
//  2 Write 0x8003 -> cfg_cpol=1, cfg_cpha=1 two clk after end_evt; unchanged before.
//  3 Read addr 0x7F with NUM_REGS=8 -> spi_tx=16'h4X00 (bad_addr). The next frame's response has bad_addr=0.
//  4 New busy rise 1 clk after end_evt -> ovr=1 in response; spi_rx_enable low CAPTURE..RESP; regs unaffected by dropped frame.
//  5 WPROT_EN: write 0x8080, then 0x8277 -> reg2 unchanged, lock_err=1. Write 0x8000 then 0x8277 -> reg2=0x77.
//  6 reset_n low during EXEC of 0x8199 -> reg1=0x00, spi_tx=0, state IDLE, no spurious end_evt while busy held high.

Source files
------------

// File: rtl/spi_reg_pkg.sv
// spi_reg_pkg: shared types, field positions and response packing
// for the SPI register controller.
package spi_reg_pkg;

  typedef enum logic [1:0] {
    IDLE,
    CAPTURE,
    EXEC,
    RESP
  } state_e;

  localparam int W_BIT    = 15;
  localparam int ADDR_MSB = 14;
  localparam int ADDR_LSB = 8;
  localparam int DATA_MSB = 7;
  localparam int DATA_LSB = 0;

  localparam int CTRL_ADDR = 0;
  localparam int CPOL_BIT  = 0;
  localparam int CPHA_BIT  = 1;
  localparam int LOCK_BIT  = 7;

  localparam int ST_OVR   = 15;
  localparam int ST_BAD   = 14;
  localparam int ST_LOCK  = 13;
  localparam int CNT_MSB  = 11;
  localparam int CNT_LSB  = 8;

  typedef struct packed {
    logic       wr;
    logic [6:0] addr;
    logic [7:0] data;
  } cmd_t;

  function automatic logic [15:0] pack_resp(
    input logic       ovr,
    input logic       bad,
    input logic       lck,
    input logic [3:0] cnt,
    input logic [7:0] rdata
  );
    logic [15:0] r;
    r                   = '0;
    r[ST_OVR]           = ovr;
    r[ST_BAD]           = bad;
    r[ST_LOCK]          = lck;
    r[CNT_MSB:CNT_LSB]  = cnt;
    r[DATA_MSB:DATA_LSB] = rdata;
    return r;
  endfunction

endpackage

// File: rtl/spi_reg_ctrl_sync.sv
// spi_busy_sync: brings the async busy level into clk and
// flags its rising (frame start) and falling (frame end) edges.
module spi_busy_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic reset_n,
  input  logic busy_i,
  output logic start_evt_o,
  output logic end_evt_o
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   edge_q;
  logic                   lvl;

  assign lvl = sync_q[SYNC_STAGES-1];

  // Loading the live level on reset hides any busy already in progress.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      sync_q <= {SYNC_STAGES{busy_i}};
      edge_q <= busy_i;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], busy_i};
      edge_q <= lvl;
    end
  end

  assign start_evt_o = lvl & ~edge_q;
  assign end_evt_o   = ~lvl & edge_q;

endmodule

// File: rtl/spi_reg_ctrl.sv
// spi_reg_ctrl: frame sequencer and register bank behind an SPI slave.
// Define SPI_REG_WPROT_EN to make CTRL[7] a write-protect lock.
module spi_reg_ctrl
  import spi_reg_pkg::*;
#(
  parameter int NUM_REGS    = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  spi_busy,
  input  logic [15:0]           spi_rx,
  output logic                  spi_rx_enable,
  output logic [15:0]           spi_tx,
  output logic                  cfg_cpol,
  output logic                  cfg_cpha,
  output logic [NUM_REGS*8-1:0] regs
);

  state_e      state_q, state_d;
  cmd_t        cmd_q, cmd_d;
  logic [7:0]  regs_q [NUM_REGS];
  logic [7:0]  regs_d [NUM_REGS];
  logic [15:0] tx_q, tx_d;
  logic [7:0]  rdata_q, rdata_d;
  logic        ovr_q, ovr_d;
  logic        bad_q, bad_d;
  logic        lck_q, lck_d;
  logic [3:0]  cnt_q, cnt_d;

  logic        start_evt;
  logic        end_evt;
  logic        hit;
  logic        locked;
  logic [7:0]  cur;

  spi_busy_sync #(
    .SYNC_STAGES (SYNC_STAGES)
  ) u_sync (
    .clk         (clk),
    .reset_n     (reset_n),
    .busy_i      (spi_busy),
    .start_evt_o (start_evt),
    .end_evt_o   (end_evt)
  );

`ifdef SPI_REG_WPROT_EN
  assign locked = regs_q[CTRL_ADDR][LOCK_BIT];
`else
  assign locked = 1'b0;
`endif

  always_comb begin
    hit = (int'(cmd_q.addr) < NUM_REGS);
    cur = '0;
    for (int k = 0; k < NUM_REGS; k++) begin
      if (cmd_q.addr == 7'(k)) cur = regs_q[k];
    end
  end

  always_comb begin
    state_d       = state_q;
    cmd_d         = cmd_q;
    regs_d        = regs_q;
    tx_d          = tx_q;
    rdata_d       = rdata_q;
    ovr_d         = ovr_q;
    bad_d         = bad_q;
    lck_d         = lck_q;
    cnt_d         = cnt_q;
    spi_rx_enable = 1'b0;
    unique case (state_q)
      IDLE: begin
        spi_rx_enable = 1'b1;
        if (end_evt) state_d = CAPTURE;
      end
      CAPTURE: begin
        cmd_d.wr   = spi_rx[W_BIT];
        cmd_d.addr = spi_rx[ADDR_MSB:ADDR_LSB];
        cmd_d.data = spi_rx[DATA_MSB:DATA_LSB];
        state_d    = EXEC;
      end
      EXEC: begin
        state_d = RESP;
        if (!hit) begin
          rdata_d = '0;
          bad_d   = 1'b1;
        end else if (cmd_q.wr) begin
          if (locked && cmd_q.addr != 7'(CTRL_ADDR)) begin
            rdata_d = cur;
            lck_d   = 1'b1;
          end else begin
            rdata_d = cmd_q.data;
            for (int k = 0; k < NUM_REGS; k++) begin
              if (cmd_q.addr == 7'(k)) regs_d[k] = cmd_q.data;
            end
          end
        end else begin
          rdata_d = cur;
        end
      end
      RESP: begin
        tx_d    = pack_resp(ovr_q, bad_q, lck_q, cnt_q, rdata_q);
        cnt_d   = cnt_q + 4'd1;
        ovr_d   = 1'b0;
        bad_d   = 1'b0;
        lck_d   = 1'b0;
        state_d = IDLE;
      end
    endcase
    // A fresh overrun outranks the clear-on-report above.
    if (state_q != IDLE && (start_evt || end_evt)) ovr_d = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q <= IDLE;
      cmd_q   <= '0;
      regs_q  <= '{default: '0};
      tx_q    <= '0;
      rdata_q <= '0;
      ovr_q   <= 1'b0;
      bad_q   <= 1'b0;
      lck_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cmd_q   <= cmd_d;
      regs_q  <= regs_d;
      tx_q    <= tx_d;
      rdata_q <= rdata_d;
      ovr_q   <= ovr_d;
      bad_q   <= bad_d;
      lck_q   <= lck_d;
      cnt_q   <= cnt_d;
    end
  end

  assign spi_tx   = tx_q;
  assign cfg_cpol = regs_q[CTRL_ADDR][CPOL_BIT];
  assign cfg_cpha = regs_q[CTRL_ADDR][CPHA_BIT];

  for (genvar g = 0; g < NUM_REGS; g++) begin : g_regs
    assign regs[8*g +: 8] = regs_q[g];
  end

endmodule
